addsub_serial: RTL and testbench
================================

# addsub_serial

Bit-serial two's-complement adder/subtractor. It accepts one operand pair per request and returns the WIDTH-bit result and a signed-overflow flag after WIDTH shift cycles. It is the sequential, handshaked execution unit that the existing self-checking add/sub bench stimulus drives: operand_a, operand_b and mode go in; result and overflow come out. It trades throughput for a single full-adder cell and serves area-constrained datapaths.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start
- operand_a  input  WIDTH  signed minuend/augend; sampled with start
- operand_b  input  WIDTH  signed subtrahend/addend; sampled with start
- busy  output  1  high in SHIFT
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  (a ± b) mod 2^WIDTH; holds between completions
- co  output  1  raw carry out of MSB stage
- ovf  output  1  signed overflow; see Configuration

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: if start=1 at an edge, latch A=operand_a, B=(mode ? ~operand_b : operand_b), carry=mode, bit counter=0, sum shift register cleared. Go to SHIFT.
- SHIFT: each edge computes s=A[0]^B[0]^carry. The new carry is the majority of the three. s shifts into the sum register MSB-side; A and B shift right. The counter increments. The carry into the MSB stage is captured when counter=WIDTH−1. After the WIDTH-th SHIFT edge, go to DONE.
- Entering DONE: result←sum register, co←final carry, ovf←(carry into MSB)^(carry out of MSB).
- DONE: done=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- Start is ignored in SHIFT and DONE: no queuing, no error flag. Operand and mode changes after acceptance have no effect.
- Arithmetic: subtraction is a + ~b + 1. Result is modulo 2^WIDTH with no saturation. For example, with WIDTH=4, −8−1 yields 4'b0111.
- Reset mid-operation aborts the current request. No done is produced for it.

## Timing
- Reset values: busy=0, done=0, result=0, co=0, ovf=0. Internal state is IDLE with counter=0 and carry=0.
- Accept edge E0 (start=1 in IDLE). busy=1 from E0 through E(WIDTH), i.e. WIDTH cycles.
- result, co and ovf update at E(WIDTH). done is high between E(WIDTH) and E(WIDTH+1), the same cycle the new result first appears.
- Earliest next accept: E(WIDTH+2), which gives an issue interval of WIDTH+2 cycles.
- done and busy are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ADDSUB_SERIAL_OVF_EN defined:
  - The MSB carry-in register and overflow logic are built.
  - ovf follows the rule above.
- Not defined:
  - The register and logic are omitted.
  - ovf is tied to 0.
  - result, co and timing are unchanged.

## Test plan
- Reset, then sub 3−5 (mode=1, a=4'b0011, b=4'b0101) → done pulse at E4, result=4'b1110, co=0, ovf=0, busy high for exactly 4 cycles.
- Add 7+1 → result=4'b1000, ovf=1 (with macro) or 0 (without). Sub −8−1 → result=4'b0111, ovf=1, co=1.
- Hold start=1 continuously with changing operands → requests are accepted only every 6 cycles. Each result matches the operands present at its accept edge.
- Assert rst_n=0 at E2 of a request → all outputs 0 immediately. No done. The next start after release completes normally.
- Exhaustive sweep: both modes, a,b ∈ [−8,7] (512 requests) → result equals (a±b)[3:0] for every request. ovf=1 exactly when the true result falls outside [−8,7]. Zero mismatches.

Source files
------------

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement adder/subtractor using a single full-adder cell.
// Optional overflow logic is built when ADDSUB_SERIAL_OVF_EN is defined; otherwise ovf is tied to 0.
module addsub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on accept
  // SHIFT | one result bit produced per edge, LSB first
  // DONE  | result/co/ovf valid, done pulses for this cycle
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    s_bit    = a_q[0] ^ b_q[0] ^ carry;
    c_next   = (a_q[0] & b_q[0]) | (a_q[0] & carry) | (b_q[0] & carry);
    sum_next = {s_bit, sum_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      co     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= operand_a;
            b_q   <= mode ? ~operand_b : operand_b;
            carry <= mode;
            cnt   <= '0;
            sum_q <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q <= sum_next;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= sum_next;
            co     <= c_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          cnt   <= '0;
          carry <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDSUB_SERIAL_OVF_EN
  // On the last shift edge 'carry' is the carry into the MSB stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (state == SHIFT && cnt == LAST)
      ovf <= carry ^ c_next;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed cases, held-start throughput,
// mid-operation reset, exhaustive sweep and random requests against an arithmetic model.
module tb_addsub_serial;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  addsub_serial #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int r, output int c, output int v);
    int sa, sb, t, u;
    sa = $signed(a);
    sb = $signed(b);
    t  = m ? sa - sb : sa + sb;
    u  = m ? int'(a) + ((~int'(b)) & 15) + 1 : int'(a) + int'(b);
    r  = t & 15;
    c  = (u >> 4) & 1;
`ifdef ADDSUB_SERIAL_OVF_EN
    v  = (t > 7 || t < -8) ? 1 : 0;
`else
    v  = 0;
`endif
  endfunction

  // One request; operands and mode are scrambled after acceptance.
  task automatic run_req(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int er, ec, ev;
    model(m, a, b, er, ec, ev);
    @(negedge clk);
    start = 1'b1; mode = m; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    check("busy_e0", busy, 1);
    check("done_e0", done, 0);
    @(negedge clk);
    start = 1'b0; mode = $urandom_range(0, 1);
    operand_a = WIDTH'($urandom); operand_b = WIDTH'($urandom);
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge clk); #1;
      check("busy_shift", busy, 1);
      check("done_shift", done, 0);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("result", result, er);
    check("co", co, ec);
    check("ovf", ovf, ev);
    @(posedge clk); #1;
    check("done_drop", done, 0);
    check("result_hold", result, er);
  endtask

  initial begin
    int er, ec, ev;
    logic             cm;
    logic [WIDTH-1:0] ca, cb;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; operand_a = '0; operand_b = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_co", co, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b1, 4'b0011, 4'b0101);
    run_req(1'b0, 4'b0111, 4'b0001);
    run_req(1'b1, 4'b1000, 4'b0001);
    run_req(1'b1, 4'b0000, 4'b0000);
    run_req(1'b0, 4'b1111, 4'b1111);

    // Held start with operands changing every cycle: accepts only every WIDTH+2 edges.
    @(negedge clk);
    start = 1'b1; mode = $urandom_range(0, 1);
    operand_a = WIDTH'($urandom); operand_b = WIDTH'($urandom);
    for (int k = 0; k < 4; k++) begin
      cm = mode; ca = operand_a; cb = operand_b;
      model(cm, ca, cb, er, ec, ev);
      @(posedge clk); #1;
      check("hold_accept", busy, 1);
      for (int c = 1; c <= WIDTH + 1; c++) begin
        @(negedge clk);
        mode = $urandom_range(0, 1);
        operand_a = WIDTH'($urandom); operand_b = WIDTH'($urandom);
        @(posedge clk); #1;
        if (c < WIDTH) begin
          check("hold_busy", busy, 1);
          check("hold_nodone", done, 0);
        end else if (c == WIDTH) begin
          check("hold_done", done, 1);
          check("hold_result", result, er);
          check("hold_co", co, ec);
          check("hold_ovf", ovf, ev);
        end else begin
          check("hold_idle_busy", busy, 0);
          check("hold_idle_done", done, 0);
        end
      end
      @(negedge clk);
      mode = $urandom_range(0, 1);
      operand_a = WIDTH'($urandom); operand_b = WIDTH'($urandom);
    end
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);

    // Reset at E2 of a request aborts it with no done.
    run_req(1'b0, 4'b0101, 4'b0001);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; operand_a = 4'b0011; operand_b = 4'b0010;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_co", co, 0);
    check("abort_ovf", ovf, 0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", done | busy, 0);
    end
    run_req(1'b1, 4'b0110, 4'b1101);

    // Exhaustive sweep, both modes.
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_req(m[0], WIDTH'(a), WIDTH'(b));

    for (int i = 0; i < 40; i++)
      run_req(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
